execute: RTL and testbench

EXECUTE -- requirements
Module: execute

---
 rtl/execute.sv | 94 +++++++++
 tb/tb_execute.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/execute.sv
// execute: single registered execute stage with a PRINT FIFO
//   clk, rst_n           - clock, asynchronous active-low reset
//   ins, val             - instruction and cell value from the select stage
//   ptr                  - current data pointer
//   branch_en, branch_pc - one-cycle branch pulse and its target
//   wb_en, wb_tag, wb_val- one-cycle writeback pulse, cell address and value
//   print_data/valid/ready - FIFO head handshake toward the consumer
//   print_stall          - upstream must not issue PRINT while high
//   print_ovf            - sticky flag, a PRINT was dropped
module execute #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] PTR_RESET  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ins,
    input  logic [15:0] val,
    output logic [15:0] ptr,
    output logic        branch_en,
    output logic [15:0] branch_pc,
    output logic        wb_en,
    output logic [15:0] wb_tag,
    output logic [15:0] wb_val,
    output logic [7:0]  print_data,
    output logic        print_valid,
    input  logic        print_ready,
    output logic        print_stall,
    output logic        print_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_ptr, r_branch_pc, r_wb_tag, r_wb_val;
    logic          r_branch_en, r_wb_en, r_ovf;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic [3:0]    w_op;
    logic          w_taken, w_push_req, w_pop, w_full, w_push;

    // The instruction after a taken branch is on the wrong path, so squash it.
    assign w_op       = r_branch_en ? 4'h0 : ins[15:12];
    assign w_taken    = (w_op == 4'h6) || (w_op == 4'h5 && val == 16'h0000);
    assign w_push_req = (w_op == 4'h8);
    assign w_pop      = print_valid && print_ready;
    assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= PTR_RESET;
            r_branch_en <= 1'b0;
            r_branch_pc <= 16'h0000;
            r_wb_en     <= 1'b0;
            r_wb_tag    <= 16'h0000;
            r_wb_val    <= 16'h0000;
            r_ovf       <= 1'b0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_cnt       <= '0;
        end else begin
            r_ptr       <= (w_op == 4'h3) ? r_ptr + 16'h0001 :
                           (w_op == 4'h4) ? r_ptr - 16'h0001 : r_ptr;
            r_branch_en <= w_taken;
            r_branch_pc <= w_taken ? {4'h0, ins[11:0]} : r_branch_pc;
            r_wb_en     <= (w_op == 4'h1) || (w_op == 4'h2);
            r_wb_tag    <= (w_op == 4'h1 || w_op == 4'h2) ? r_ptr : r_wb_tag;
            r_wb_val    <= (w_op == 4'h1) ? val + 16'h0001 :
                           (w_op == 4'h2) ? val - 16'h0001 : r_wb_val;
            r_ovf       <= r_ovf || (w_push_req && !w_push);
            r_wr        <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd        <= w_pop ? r_rd + 1'b1 : r_rd;
            r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: the count gates everything read from it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= val[7:0];
    end

    assign ptr         = r_ptr;
    assign branch_en   = r_branch_en;
    assign branch_pc   = r_branch_pc;
    assign wb_en       = r_wb_en;
    assign wb_tag      = r_wb_tag;
    assign wb_val      = r_wb_val;
    assign print_valid = (r_cnt != '0);
    assign print_data  = print_valid ? r_mem[r_rd] : 8'h00;
    assign print_ovf   = r_ovf;
    // One slot of headroom covers a PRINT already in flight when stall rises.
    assign print_stall = rst_n && ((r_cnt >= CW'(FIFO_DEPTH - 1)) || w_push_req);
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed self-checking bench for execute
module tb_execute;
    logic        clk, rst_n, branch_en, wb_en, print_valid, print_ready, print_stall, print_ovf;
    logic [15:0] ins, val, ptr, branch_pc, wb_tag, wb_val;
    logic [7:0]  print_data;
    int          n_chk = 0, n_err = 0;

    execute #(.FIFO_DEPTH(4), .PTR_RESET(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .val(val), .ptr(ptr),
        .branch_en(branch_en), .branch_pc(branch_pc),
        .wb_en(wb_en), .wb_tag(wb_tag), .wb_val(wb_val),
        .print_data(print_data), .print_valid(print_valid), .print_ready(print_ready),
        .print_stall(print_stall), .print_ovf(print_ovf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] i, input logic [15:0] v);
        ins = i;
        val = v;
        step();
    endtask

    initial begin
        rst_n = 0; ins = 0; val = 0; print_ready = 0;
        #23;
        chk("rst_ptr", ptr, 16'h0000);
        chk("rst_wb_en", 16'(wb_en), 16'h0);
        chk("rst_br_en", 16'(branch_en), 16'h0);
        chk("rst_valid", 16'(print_valid), 16'h0);
        chk("rst_data", 16'(print_data), 16'h0);
        chk("rst_stall", 16'(print_stall), 16'h0);
        chk("rst_ovf", 16'(print_ovf), 16'h0);
        rst_n = 1;
        step();
        // arithmetic writeback
        issue(16'h1000, 16'hFFFF);
        chk("plus_en", 16'(wb_en), 16'h1);
        chk("plus_tag", wb_tag, 16'h0000);
        chk("plus_val", wb_val, 16'h0000);
        issue(16'h2000, 16'h0005);
        chk("minus_val", wb_val, 16'h0004);
        issue(16'h0000, 16'h1234);
        chk("nop_wb_en", 16'(wb_en), 16'h0);
        chk("hold_wb_val", wb_val, 16'h0004);
        // pointer moves
        issue(16'h4000, 16'h0000);
        chk("left_ptr", ptr, 16'hFFFF);
        issue(16'h1000, 16'h0007);
        chk("plus_tag_ffff", wb_tag, 16'hFFFF);
        chk("plus_val_8", wb_val, 16'h0008);
        issue(16'h3000, 16'h0000);
        chk("right_ptr", ptr, 16'h0000);
        // branches
        issue(16'h5123, 16'h0000);
        chk("brz_en", 16'(branch_en), 16'h1);
        chk("brz_pc", branch_pc, 16'h0123);
        issue(16'h6456, 16'h0000);
        chk("squash_en", 16'(branch_en), 16'h0);
        chk("squash_pc", branch_pc, 16'h0123);
        issue(16'h5123, 16'h0001);
        chk("brz_nz_en", 16'(branch_en), 16'h0);
        issue(16'h6456, 16'h0001);
        chk("jmp_en", 16'(branch_en), 16'h1);
        chk("jmp_pc", branch_pc, 16'h0456);
        issue(16'h7FFF, 16'h0000);
        chk("op7_br", 16'(branch_en), 16'h0);
        chk("op7_wb", 16'(wb_en), 16'h0);
        chk("op7_ptr", ptr, 16'h0000);
        // overflow: five PRINTs into a depth-4 FIFO
        ins = 16'h8000; val = 16'h0041;
        #1;
        chk("stall_inflight", 16'(print_stall), 16'h1);
        chk("no_bypass", 16'(print_valid), 16'h0);
        step();
        chk("valid_next", 16'(print_valid), 16'h1);
        chk("head_a", 16'(print_data), 16'h0041);
        issue(16'h8000, 16'h0042);
        issue(16'h8000, 16'h0043);
        ins = 0;
        #1;
        chk("stall_cnt3", 16'(print_stall), 16'h1);
        issue(16'h8000, 16'h0044);
        chk("ovf_clear", 16'(print_ovf), 16'h0);
        issue(16'h8000, 16'h0045);
        chk("ovf_set", 16'(print_ovf), 16'h1);
        ins = 0;
        print_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain", 16'(print_data), 16'h0041 + 16'(i));
            step();
        end
        chk("drained", 16'(print_valid), 16'h0);
        chk("stall_empty", 16'(print_stall), 16'h0);
        chk("ovf_sticky", 16'(print_ovf), 16'h1);
        // full FIFO with simultaneous push and pop
        print_ready = 0;
        rst_n = 0;
        #2;
        chk("rst_ovf2", 16'(print_ovf), 16'h0);
        rst_n = 1;
        step();
        for (int i = 0; i < 4; i++) issue(16'h8000, 16'h0031 + 16'(i));
        print_ready = 1;
        issue(16'h8000, 16'h0035);
        print_ready = 0;
        ins = 0;
        chk("full_pp_ovf", 16'(print_ovf), 16'h0);
        chk("full_pp_stall", 16'(print_stall), 16'h1);
        print_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", 16'(print_data), 16'h0032 + 16'(i));
            step();
        end
        chk("pp_empty", 16'(print_valid), 16'h0);
        print_ready = 0;
        // mid-operation reset
        issue(16'h3000, 16'h0000);
        for (int i = 0; i < 3; i++) issue(16'h8000, 16'h0061 + 16'(i));
        issue(16'h1000, 16'h0009);
        chk("pre_wb_en", 16'(wb_en), 16'h1);
        chk("pre_wb_tag", wb_tag, 16'h0001);
        chk("pre_valid", 16'(print_valid), 16'h1);
        ins = 0;
        #1;
        rst_n = 0;
        #1;
        chk("mid_valid", 16'(print_valid), 16'h0);
        chk("mid_wb_en", 16'(wb_en), 16'h0);
        chk("mid_ptr", ptr, 16'h0000);
        chk("mid_wb_tag", wb_tag, 16'h0000);
        chk("mid_data", 16'(print_data), 16'h0);
        #10;
        rst_n = 1;
        step();
        issue(16'h3000, 16'h0000);
        chk("resume_ptr", ptr, 16'h0001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
